// File: rtl/ariscv_pkg.sv
// rtl/ariscv_pkg.sv - shared types and defaults for the ariscv fetch controller
//
// Purpose: holds the fetch FSM state encoding and the default width of the
// fetched-instruction counter, so that every file uses the same definitions.
// Ports: none (package).
package ariscv_pkg;

  localparam int CNT_NBW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ariscv_fetch_ctrl.sv
// rtl/ariscv_fetch_ctrl.sv - instruction fetch sequencing FSM with delivered-instruction counter
//
// Purpose: issues one instruction-memory request at a time, loads the
// fetch/decode register on each response, handles branch/jump redirects
// (including a response that is already in flight) and counts delivered
// instructions.
// Ports:
//   aclk, rst_async_n        clock, asynchronous active-low reset
//   i_start                  level, fetching enabled
//   o_imem_req / i_imem_ack  one-cycle request / response pulses
//   i_dec_ready              decode consumes the fetch/decode register
//   i_redirect               one-cycle taken branch/jump, target valid
//   o_pc_en, o_pc_src        PC load strobe and mux select (0 = PC+4, 1 = target)
//   o_fd_en, o_fd_valid      fetch/decode register load strobe and valid flag
//   o_busy                   FSM is not idle
//   o_fetch_cnt              number of instructions delivered (wraps)
module ariscv_fetch_ctrl
  import ariscv_pkg::*;
#(
  parameter int CNT_NBW = CNT_NBW_DEFAULT
) (
  input  logic               aclk,
  input  logic               rst_async_n,
  input  logic               i_start,
  output logic               o_imem_req,
  input  logic               i_imem_ack,
  input  logic               i_dec_ready,
  input  logic               i_redirect,
  output logic               o_pc_en,
  output logic               o_pc_src,
  output logic               o_fd_en,
  output logic               o_fd_valid,
  output logic               o_busy,
  output logic [CNT_NBW-1:0] o_fetch_cnt
);

  fetch_state_e        state_q, state_d;
  logic                discard_q, discard_d;
  logic                fd_valid_q, fd_valid_d;
  logic [CNT_NBW-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic                imem_req;
  logic                pc_en;
  logic                pc_src;
  logic                fd_en;
  logic                load;

  always_ff @(posedge aclk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      fd_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      fd_valid_q  <= fd_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    fd_valid_d  = fd_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    fd_en       = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A request is only launched if the fetch/decode slot will be free
        // when the response lands, and never in a redirect cycle (the PC is
        // being reloaded and would be stale on the memory side).
        if (!i_start) begin
          state_d = ST_IDLE;
        end else if ((!fd_valid_q || i_dec_ready) && !i_redirect) begin
          imem_req = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_imem_ack) begin
          state_d   = ST_ISSUE;
          discard_d = 1'b0;
          // A response fetched from the old path (earlier redirect) or
          // arriving together with a redirect is dropped.
          if (!discard_q && !i_redirect) begin
            load = 1'b1;
          end
        end else if (i_redirect) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      fd_en       = 1'b1;
      pc_en       = 1'b1;
      fetch_cnt_d = fetch_cnt_q + CNT_NBW'(1);
    end

    // Consume clears the slot unless a new instruction is loaded the same cycle.
    if (fd_valid_q && i_dec_ready) begin
      fd_valid_d = 1'b0;
    end
    if (load) begin
      fd_valid_d = 1'b1;
    end

    // Redirect takes the target in any state and flushes the slot.
    if (i_redirect) begin
      pc_en      = 1'b1;
      pc_src     = 1'b1;
      fd_valid_d = 1'b0;
    end
  end

  // Strobes depend on live inputs, so they are masked while reset is held.
  assign o_imem_req  = imem_req & rst_async_n;
  assign o_pc_en     = pc_en & rst_async_n;
  assign o_pc_src    = pc_src & rst_async_n;
  assign o_fd_en     = fd_en & rst_async_n;
  assign o_fd_valid  = fd_valid_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_fetch_cnt = fetch_cnt_q;

endmodule
